// File: rtl/acc_pointop.sv
// acc_pointop: point-operation image accelerator.
//
// Streams a packed grayscale image from word address 0 of a single-port memory,
// applies a per-pixel operation to every lane of each word and writes the
// result image starting at DST_OFFSET. Each word takes one READ and one WRITE
// cycle, so the memory is never read and written in the same cycle.
//
// Parameters
//   IMG_W, IMG_H   image size in pixels
//   PIX_W          bits per pixel
//   PIX_PER_WORD   pixels packed per memory word
//   ADDR_W         memory word-address width
//   DST_OFFSET     word address of the first result word
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   addr    out  memory word address
//   dataR   in   memory read data, valid the cycle after a read
//   dataW   out  memory write data (f(dataR) during WRITE, else 0)
//   en      out  memory access enable
//   we      out  write enable, qualified by en
//   start   in   level request to process one image
//   finish  out  image complete, held until start drops
//   mode    in   0 copy, 1 invert, 2 threshold, 3 saturating add
//   param   in   threshold level (mode 2) or addend (mode 3)

module acc_pointop #(
    parameter int unsigned IMG_W        = 352,
    parameter int unsigned IMG_H        = 288,
    parameter int unsigned PIX_W        = 8,
    parameter int unsigned PIX_PER_WORD = 4,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DST_OFFSET   = IMG_W * IMG_H / PIX_PER_WORD,
    localparam int unsigned DATA_W      = PIX_W * PIX_PER_WORD
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataR,
    output logic [DATA_W-1:0] dataW,
    output logic              en,
    output logic              we,
    input  logic              start,
    output logic              finish,
    input  logic [1:0]        mode,
    input  logic [PIX_W-1:0]  param
);

    // Words per image.
    localparam int unsigned N = IMG_W * IMG_H / PIX_PER_WORD;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] DstBase = ADDR_W'(DST_OFFSET);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((IMG_W * IMG_H) % PIX_PER_WORD != 0) begin : g_err_packing
        $error("acc_pointop: IMG_W*IMG_H must be a multiple of PIX_PER_WORD");
    end

    if ((64'(DST_OFFSET) + 64'(N)) > (64'd1 << ADDR_W)) begin : g_err_range
        $error("acc_pointop: DST_OFFSET + N exceeds the address space");
    end

    // ------------------------------------------------------------------
    // Types and state
    // ------------------------------------------------------------------
    // StLatch is kept for continuity with the previous acc block; the mode and
    // param capture happens in the IDLE cycle that samples start, so the FSM
    // never lingers there.
    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StRead,
        StWrite,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        OpCopy,
        OpInvert,
        OpThresh,
        OpSatAdd
    } op_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    op_e                mode_q, mode_d;
    logic [PIX_W-1:0]   param_q, param_d;

    logic               en_q, en_d;
    logic               we_q, we_d;
    logic               finish_q, finish_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            mode_q   <= OpCopy;
            param_q  <= '0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            finish_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            param_q  <= param_d;
            en_q     <= en_d;
            we_q     <= we_d;
            finish_q <= finish_d;
            addr_q   <= addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        param_d = param_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = op_e'(mode);
                    param_d = param;
                    idx_d   = '0;
                    state_d = StRead;
                end
            end
            StLatch: begin
                state_d = StRead;
            end
            StRead: begin
                state_d = StWrite;
            end
            StWrite: begin
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = StRead;
                end
            end
            StDone: begin
                // Wait for start to drop so a held request cannot retrigger.
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: decoded from the next state so the memory controls come
    // straight out of flops, aligned with the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        en_d     = 1'b0;
        we_d     = 1'b0;
        finish_d = 1'b0;
        addr_d   = '0;

        unique case (state_d)
            StRead: begin
                en_d   = 1'b1;
                addr_d = idx_d;
            end
            StWrite: begin
                en_d   = 1'b1;
                we_d   = 1'b1;
                addr_d = DstBase + idx_d;
            end
            StDone: begin
                finish_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign en     = en_q;
    assign we     = we_q;
    assign finish = finish_q;
    assign addr   = addr_q;

    // ------------------------------------------------------------------
    // Per-lane point operation on the word returned by the preceding READ
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] result;
    logic [PIX_W-1:0]  lane;
    logic [PIX_W:0]    sum;

    always_comb begin
        result = '0;
        lane   = '0;
        sum    = '0;
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            lane = dataR[k*PIX_W +: PIX_W];
            // One extra bit catches overflow of the lane only; lanes stay independent.
            sum  = {1'b0, lane} + {1'b0, param_q};
            unique case (mode_q)
                OpCopy:   result[k*PIX_W +: PIX_W] = lane;
                OpInvert: result[k*PIX_W +: PIX_W] = ~lane;
                OpThresh: result[k*PIX_W +: PIX_W] = (lane >= param_q) ? {PIX_W{1'b1}} : '0;
                OpSatAdd: result[k*PIX_W +: PIX_W] = sum[PIX_W] ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
                default:  result[k*PIX_W +: PIX_W] = lane;
            endcase
        end
    end

    assign dataW = (state_q == StWrite) ? result : '0;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_we_needs_en : assert property (@(posedge clk) disable iff (reset) we |-> en);
    a_no_access_when_done : assert property (@(posedge clk) disable iff (reset) finish |-> !en);

endmodule

// File: tb/tb_acc_pointop.sv
// Self-checking bench for acc_pointop on an 8x2 image (N = 4 words, results at 4..7).
// Stimulus pushes the expected memory-access sequence into a scoreboard queue; a
// negedge monitor pops and compares every access the DUT makes.

module tb_acc_pointop;

    localparam int unsigned NW  = 4;
    localparam int unsigned DST = 4;
    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  param;
    logic [15:0] addr;
    logic [31:0] dataR;
    logic [31:0] dataW;
    logic        en;
    logic        we;
    logic        finish;

    always #5 clk = ~clk;

    acc_pointop #(
        .IMG_W        (8),
        .IMG_H        (2),
        .PIX_W        (8),
        .PIX_PER_WORD (4),
        .ADDR_W       (16),
        .DST_OFFSET   (DST)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .dataR  (dataR),
        .dataW  (dataW),
        .en     (en),
        .we     (we),
        .start  (start),
        .finish (finish),
        .mode   (mode),
        .param  (param)
    );

    // Single-port memory, one-cycle read latency.
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (en === 1'b1) begin
            if (we) mem[addr[3:0]] = dataW;
            else    dataR <= mem[addr[3:0]];
        end
    end

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t sb_q[$];
    acc_t mon_a;
    acc_t mon_e;
    int checks   = 0;
    int failures = 0;

    logic [31:0] vin  [4];
    logic [31:0] vexp [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every memory access must match the next expected one.
    always @(negedge clk) begin
        if (en === 1'b1) begin
            mon_a.we   = we;
            mon_a.addr = addr;
            mon_a.data = we ? dataW : 32'h0;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_access: got we=%0b addr=%h data=%h required none",
                         we, addr, dataW);
            end else begin
                mon_e = sb_q.pop_front();
                check("access", {15'd0, mon_a}, {15'd0, mon_e});
            end
        end
    end

    task automatic load_mem();
        for (int j = 0; j < NW; j++) begin
            mem[j]       = vin[j];
            mem[DST + j] = SENT;
        end
    endtask

    task automatic push_run(input int nwords);
        for (int j = 0; j < nwords; j++) begin
            sb_q.push_back({1'b0, 16'(j), 32'h0});
            sb_q.push_back({1'b1, 16'(DST + j), vexp[j]});
        end
    endtask

    // Called just after edge 0; finish must appear right after edge 2N, i.e. cycle 2N+1.
    task automatic wait_finish(input string tag);
        int got;
        got = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (got < 0 && finish === 1'b1) got = e;
        end
        check({tag, "_finish_edge"}, 64'(got), 64'(2 * NW));
    endtask

    task automatic do_run(input logic [1:0] m, input logic [7:0] p, input string tag);
        bit held;
        mode  = m;
        param = p;
        push_run(NW);
        start = 1'b1;
        @(posedge clk);          // edge 0
        #1;
        mode  = ~m;              // must not affect the run in progress
        param = ~p;
        wait_finish(tag);
        check({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
        for (int j = 0; j < NW; j++) begin
            check({tag, "_result_word"}, 64'(mem[DST + j]), 64'(vexp[j]));
        end
        held = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (finish !== 1'b1) held = 1'b0;
        end
        check({tag, "_finish_held"}, 64'(held), 64'd1);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_finish_drop"}, 64'(finish), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b1;
        mode  = 2'd0;
        param = 8'd0;
        for (int j = 0; j < 16; j++) mem[j] = 32'h0;

        // Copy vectors, loaded before reset so the run can start as reset drops.
        vin  = '{32'h0102_0304, 32'hA0B0_C0D0, 32'hFFFF_FFFF, 32'h0000_0000};
        vexp = '{32'h0102_0304, 32'hA0B0_C0D0, 32'hFFFF_FFFF, 32'h0000_0000};
        load_mem();

        // Reset held with start high: everything quiet.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("reset_outs", {13'd0, en, we, finish, addr, dataW}, 64'd0);
        end
        reset = 1'b0;
        do_run(2'd0, 8'h00, "copy");

        vin  = '{32'h00FF_7F10, 32'h0102_0304, 32'hA0B0_C0D0, 32'h1234_5678};
        vexp = '{32'hFF00_80EF, 32'hFEFD_FCFB, 32'h5F4F_3F2F, 32'hEDCB_A987};
        load_mem();
        do_run(2'd1, 8'h00, "invert");

        vin  = '{32'h7F80_FF00, 32'h8181_8181, 32'h0001_0203, 32'h8000_0080};
        vexp = '{32'h00FF_FF00, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFF00_00FF};
        load_mem();
        do_run(2'd2, 8'h80, "thresh");

        vin  = '{32'hF0E0_1000, 32'hDFE0_E1FF, 32'h0102_0304, 32'h7FFF_DE00};
        vexp = '{32'hFFFF_3020, 32'hFFFF_FFFF, 32'h2122_2324, 32'h9FFF_FE20};
        load_mem();
        do_run(2'd3, 8'h20, "satadd");

        // Reset during the WRITE of word 2 (cycle 6): that write lands, nothing after.
        vin  = '{32'h00FF_7F10, 32'h0102_0304, 32'hA0B0_C0D0, 32'h1234_5678};
        vexp = '{32'hFF00_80EF, 32'hFEFD_FCFB, 32'h5F4F_3F2F, 32'hEDCB_A987};
        load_mem();
        mode  = 2'd1;
        param = 8'h00;
        push_run(3);
        start = 1'b1;
        @(posedge clk);          // edge 0
        #1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_in_write", {47'd0, we, addr}, {47'd0, 1'b1, 16'd6});
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_en_low", {62'd0, en, finish}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_sb_drained", 64'(sb_q.size()), 64'd0);
        check("midrst_word6", 64'(mem[6]), 64'(vexp[2]));
        check("midrst_word7", 64'(mem[7]), 64'(SENT));

        // Full rerun after the aborted one.
        vin  = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00};
        vexp = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00};
        load_mem();
        do_run(2'd0, 8'h00, "rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
